// File: rtl/l1_mem_arb.sv
// l1_mem_arb: port scheduler for one 1R+1W L1 data/tag array with self-init.
// Holds off all traffic until the array reports ready. Arbitrates the refill
// (wr0) and store (wr1) writers onto the single write port, with a starvation
// limit for stores. Resolves same-address read/write collisions.
// Build option: define L1_ARB_BYPASS_EN to forward colliding write data to the
// read (write-first) instead of stalling the read for one cycle.
module l1_mem_arb #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1024,
  parameter int STARVE_LIM = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_ready,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_gnt,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr0_req,
  input  logic [AW-1:0]    wr0_addr,
  input  logic [WIDTH-1:0] wr0_data,
  output logic             wr0_gnt,
  input  logic             wr1_req,
  input  logic [AW-1:0]    wr1_addr,
  input  logic [WIDTH-1:0] wr1_data,
  output logic             wr1_gnt,
  output logic             mem_ren,
  output logic [AW-1:0]    mem_raddr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_wen,
  output logic [AW-1:0]    mem_waddr,
  output logic [WIDTH-1:0] mem_wdata
);

  // state   | meaning
  // ST_INIT | array not ready (or just reset); no grants issued
  // ST_RUN  | array usable; reads and writes are scheduled
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t     state_q, state_d;
  logic [3:0] starve_q;
  logic       rd_valid_q;
  logic       active;
  logic       wr1_force;
  logic       collision;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // Next state, write arbitration and read gating.
  always_comb begin
    state_d   = state_q;
    active    = 1'b0;
    wr1_force = (starve_q == LIM);
    wr0_gnt   = 1'b0;
    wr1_gnt   = 1'b0;
    mem_waddr = wr0_addr;
    mem_wdata = wr0_data;
    case (state_q)
      ST_INIT: if (mem_ready) state_d = ST_RUN;
      ST_RUN: begin
        // Ready dropping in RUN blocks grants in that same cycle.
        if (!mem_ready) state_d = ST_INIT;
        else            active  = !rst;
      end
      default: state_d = ST_INIT;
    endcase
    if (active) begin
      if (wr1_req && (wr1_force || !wr0_req)) wr1_gnt = 1'b1;
      else if (wr0_req)                       wr0_gnt = 1'b1;
    end
    if (wr1_gnt) begin
      mem_waddr = wr1_addr;
      mem_wdata = wr1_data;
    end
    mem_wen   = wr0_gnt | wr1_gnt;
    collision = rd_req & mem_wen & (rd_addr == mem_waddr);
`ifdef L1_ARB_BYPASS_EN
    rd_gnt    = active;
`else
    rd_gnt    = active & ~collision;
`endif
    mem_ren   = rd_req & rd_gnt;
    mem_raddr = rd_addr;
  end

  // Store starvation counter; only denials during active arbitration count.
  always_ff @(posedge clk) begin
    if (rst)                                  starve_q <= '0;
    else if (!active || !wr1_req || wr1_gnt)  starve_q <= '0;
    else if (starve_q != LIM)                 starve_q <= starve_q + 4'd1;
  end

  // Read-valid pipeline stage matching the array's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) rd_valid_q <= 1'b0;
    else     rd_valid_q <= mem_ren;
  end

  // A reset arriving while a read is in flight drops that read immediately.
  assign rd_valid = rd_valid_q & ~rst;

`ifdef L1_ARB_BYPASS_EN
  logic             byp_r;
  logic [WIDTH-1:0] byp_data_r;

  // Capture the colliding write so the read returns the written value.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_r      <= 1'b0;
      byp_data_r <= '0;
    end else begin
      byp_r <= collision;
      if (collision) byp_data_r <= mem_wdata;
    end
  end

  assign rd_data = !rd_valid ? '0 : (byp_r ? byp_data_r : mem_rdata);
`else
  assign rd_data = rd_valid ? mem_rdata : '0;
`endif

endmodule

// File: tb/tb_l1_mem_arb.sv
// Bench for l1_mem_arb: directed stimulus with literal expectations plus a
// per-cycle behavioural model of the grant/read rules and array contents.
module tb_l1_mem_arb;
  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int LIM   = 4;
`ifdef L1_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1, mem_ready = 1'b0;
  logic             rd_req = 1'b0;
  logic [AW-1:0]    rd_addr = '0;
  logic             wr0_req = 1'b0, wr1_req = 1'b0;
  logic [AW-1:0]    wr0_addr = '0, wr1_addr = '0;
  logic [WIDTH-1:0] wr0_data = '0, wr1_data = '0;
  logic             rd_gnt, rd_valid, wr0_gnt, wr1_gnt, mem_ren, mem_wen;
  logic [WIDTH-1:0] rd_data, mem_wdata;
  logic [WIDTH-1:0] mem_rdata = '0;
  logic [AW-1:0]    mem_raddr, mem_waddr;

  // second instance at the STARVE_LIM=1 boundary, write side only checked
  logic             b_rd_gnt, b_rd_valid, b_wr0_gnt, b_wr1_gnt, b_mem_ren, b_mem_wen;
  logic [WIDTH-1:0] b_rd_data, b_mem_wdata;
  logic [AW-1:0]    b_mem_raddr, b_mem_waddr;
  logic [WIDTH-1:0] b_mem_rdata = '0;

  l1_mem_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata));

  l1_mem_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIM(1)) dut_lim1 (
    .clk(clk), .rst(rst), .mem_ready(mem_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(b_rd_gnt), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(b_wr0_gnt),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(b_wr1_gnt),
    .mem_ren(b_mem_ren), .mem_raddr(b_mem_raddr), .mem_rdata(b_mem_rdata),
    .mem_wen(b_mem_wen), .mem_waddr(b_mem_waddr), .mem_wdata(b_mem_wdata));

  // array model: registered read, one-cycle latency
  logic [WIDTH-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (mem_wen) sram[mem_waddr] <= mem_wdata;
    if (mem_ren) mem_rdata <= sram[mem_raddr];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model state
  bit               m_run = 1'b0;
  int               m_starve = 0;
  bit               m_pend = 1'b0;
  logic [WIDTH-1:0] m_pdata = '0;
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               e_act, e_wr0, e_wr1, e_wen, e_coll, e_rdg, e_ren, e_rv;
  logic [AW-1:0]    e_waddr;
  logic [WIDTH-1:0] e_wdata;

  // Per-cycle compare against the model, then advance the model one cycle.
  always @(negedge clk) begin
    e_act   = m_run && mem_ready && !rst;
    e_wr1   = e_act && wr1_req && (!wr0_req || m_starve >= LIM);
    e_wr0   = e_act && wr0_req && !e_wr1;
    e_wen   = e_wr0 || e_wr1;
    e_waddr = e_wr1 ? wr1_addr : wr0_addr;
    e_wdata = e_wr1 ? wr1_data : wr0_data;
    e_coll  = rd_req && e_wen && (rd_addr == e_waddr);
    e_rdg   = e_act && (BYP || !e_coll);
    e_ren   = rd_req && e_rdg;
    e_rv    = m_pend && !rst;

    chk("m_wr0_gnt", 32'(wr0_gnt), 32'(e_wr0));
    chk("m_wr1_gnt", 32'(wr1_gnt), 32'(e_wr1));
    chk("m_mem_wen", 32'(mem_wen), 32'(e_wen));
    chk("m_rd_gnt",  32'(rd_gnt),  32'(e_rdg));
    chk("m_mem_ren", 32'(mem_ren), 32'(e_ren));
    chk("m_rd_valid", 32'(rd_valid), 32'(e_rv));
    if (e_wen) begin
      chk("m_mem_waddr", 32'(mem_waddr), 32'(e_waddr));
      chk("m_mem_wdata", mem_wdata, e_wdata);
    end
    if (e_ren) chk("m_mem_raddr", 32'(mem_raddr), 32'(rd_addr));
    if (e_rv)  chk("m_rd_data", rd_data, m_pdata);

    if (e_wen) m_mem[e_waddr] = e_wdata;
    if (rst) begin
      m_run = 1'b0; m_starve = 0; m_pend = 1'b0;
    end else begin
      m_run = mem_ready;
      if (!e_act || !wr1_req || e_wr1) m_starve = 0;
      else if (m_starve < LIM)         m_starve = m_starve + 1;
      m_pend  = e_ren;
      m_pdata = m_mem[rd_addr];
    end
  end

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  // Directed scenarios with hand-computed expectations.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]  = '0;
      m_mem[i] = '0;
    end
    to_next();

    // T1: held in reset/init, ready at cycle 10, first grant at cycle 11
    wr0_req = 1'b1; wr0_addr = 10'h3FF; wr0_data = 32'hDEADBEEF;
    for (int c = 0; c < 12; c++) begin
      rst = (c < 2); mem_ready = (c >= 10);
      to_neg();
      chk("t1_wr0_gnt", 32'(wr0_gnt), 32'(c == 11));
      if (c == 1) begin
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
      end
      to_next();
    end

    // T2: read back the refill at DEPTH-1
    wr0_req = 1'b0; rd_req = 1'b1; rd_addr = 10'h3FF;
    to_neg(); chk("t2_rd_gnt", 32'(rd_gnt), 32'h1); to_next();
    rd_req = 1'b0;
    to_neg(); chk("t2_rd_valid", 32'(rd_valid), 32'h1); chk("t2_rd_data", rd_data, 32'hDEADBEEF); to_next();

    // T3: continuous contention; LIM=4 -> 4 wr0 then 1 wr1; LIM=1 -> alternate
    wr0_req = 1'b1; wr0_addr = 10'h040; wr0_data = 32'hAAAA0000;
    wr1_req = 1'b1; wr1_addr = 10'h050; wr1_data = 32'hBBBB0000;
    for (int i = 0; i < 10; i++) begin
      to_neg();
      chk("t3_wr1_gnt", 32'(wr1_gnt), 32'(i % 5 == 4));
      chk("t3_wr0_gnt", 32'(wr0_gnt), 32'(i % 5 != 4));
      chk("t3_lim1_wr1_gnt", 32'(b_wr1_gnt), 32'(i % 2 == 1));
      chk("t3_lim1_wr0_gnt", 32'(b_wr0_gnt), 32'(i % 2 == 0));
      chk("t3_lim1_waddr", 32'(b_mem_waddr), (i % 2 == 1) ? 32'h050 : 32'h040);
      chk("t3_lim1_wen", 32'(b_mem_wen), 32'h1);
      to_next();
    end

    // T4: store and read to the same address in the same cycle
    wr0_req = 1'b0; wr1_addr = 10'h010; wr1_data = 32'h12345678;
    rd_req = 1'b1; rd_addr = 10'h010;
    to_neg();
    chk("t4_wr1_gnt", 32'(wr1_gnt), 32'h1);
`ifdef L1_ARB_BYPASS_EN
    chk("t4_rd_gnt", 32'(rd_gnt), 32'h1);
    to_next();
    wr1_req = 1'b0; rd_req = 1'b0;
    to_neg();
    chk("t4_rd_valid", 32'(rd_valid), 32'h1);
    chk("t4_rd_data", rd_data, 32'h12345678);
    to_next();
`else
    chk("t4_rd_stall", 32'(rd_gnt), 32'h0);
    to_next();
    wr1_req = 1'b0;
    to_neg(); chk("t4_rd_retry_gnt", 32'(rd_gnt), 32'h1); to_next();
    rd_req = 1'b0;
    to_neg();
    chk("t4_rd_valid", 32'(rd_valid), 32'h1);
    chk("t4_rd_data", rd_data, 32'h12345678);
    to_next();
`endif

    // back-to-back reads across address 0 and DEPTH-1
    rd_req = 1'b1; rd_addr = 10'h3FF;
    wr0_req = 1'b1; wr0_addr = 10'h000; wr0_data = 32'hA5A5A5A5;
    to_neg(); chk("b2b_wr0_gnt", 32'(wr0_gnt), 32'h1); chk("b2b_rd_gnt0", 32'(rd_gnt), 32'h1); to_next();
    wr0_req = 1'b0; rd_addr = 10'h010;
    to_neg(); chk("b2b_data0", rd_data, 32'hDEADBEEF); chk("b2b_rd_gnt1", 32'(rd_gnt), 32'h1); to_next();
    rd_addr = 10'h000;
    to_neg(); chk("b2b_data1", rd_data, 32'h12345678); to_next();
    rd_req = 1'b0;
    to_neg(); chk("b2b_data2", rd_data, 32'hA5A5A5A5); to_next();

    // T5: reset the cycle after a granted read
    wr0_req = 1'b1; wr0_addr = 10'h020; wr0_data = 32'h11111111;
    wr1_req = 1'b1; wr1_addr = 10'h030; wr1_data = 32'h22222222;
    rd_req = 1'b1; rd_addr = 10'h3FF;
    to_neg(); chk("t5_wr0_gnt", 32'(wr0_gnt), 32'h1); chk("t5_rd_gnt", 32'(rd_gnt), 32'h1); to_next();
    rst = 1'b1; rd_req = 1'b0;
    to_neg();
    chk("t5_rd_valid_drop", 32'(rd_valid), 32'h0);
    chk("t5_wen_in_rst", 32'(mem_wen), 32'h0);
    to_next();
    rst = 1'b0;
    to_neg(); chk("t5_wen_init", 32'(mem_wen), 32'h0); to_next();
    for (int i = 0; i < 5; i++) begin
      to_neg();
      chk("t5_wr1_gnt", 32'(wr1_gnt), 32'(i == 4));
      chk("t5_wr0_gnt", 32'(wr0_gnt), 32'(i != 4));
      to_next();
    end

    // T6: ready drops for 3 cycles with all requests high
    rd_req = 1'b1; rd_addr = 10'h100;
    to_neg(); chk("t6_rd_gnt_pre", 32'(rd_gnt), 32'h1); to_next();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("t6_wen_off", 32'(mem_wen), 32'h0);
      chk("t6_rd_gnt_off", 32'(rd_gnt), 32'h0);
      if (i == 0) chk("t6_rd_valid_completes", 32'(rd_valid), 32'h1);
      to_next();
    end
    mem_ready = 1'b1;
    to_neg(); chk("t6_rd_gnt_resample", 32'(rd_gnt), 32'h0); chk("t6_wen_resample", 32'(mem_wen), 32'h0); to_next();
    to_neg(); chk("t6_rd_gnt_resume", 32'(rd_gnt), 32'h1); chk("t6_wen_resume", 32'(mem_wen), 32'h1); to_next();

    rd_req = 1'b0; wr0_req = 1'b0; wr1_req = 1'b0;
    to_next();
    to_next();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
